pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, generic pipeline stage register; successor to the fixed-field ID/EX style latch.
- Carries an opaque data word plus a control word between any two pipeline stages, using a valid/ready handshake.
- Contains a 2-entry skid buffer so ready_o is registered, and supports stall, flush (bubble insertion) and a saturating stall-cycle counter.
- One instance per pipeline boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64, width of the payload word (PC, operands, immediate, register addresses, packed by the instantiating stage).
- CTRL_W, 8, width of the control word (RegWrite, MemRead, MemWrite, ALUOp, ...); forced to zero on bubbles.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- start_i  in  1  asynchronous, active-low reset (low = reset).
- flush_i  in  1  synchronous flush: discard all held entries.
- stall_i  in  1  hold request from the hazard unit: block output transfer.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry (registered).
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control.
- valid_o  out  1  output entry valid.
- ready_i  in  1  downstream accepts.
- data_o  out  DATA_W  output payload.
- ctrl_o  out  CTRL_W  output control; zero whenever valid_o=0.
- stall_cnt_o  out  CNT_W  count of cycles with valid_o=1 and no output transfer.

Behaviour:
- Reset (start_i=0, asynchronous, independent of the clock):
  - state=EMPTY, valid_o=0, ready_o=1, data_o=0, ctrl_o=0, stall_cnt_o=0; skid entry cleared.
  - Reset takes effect mid-transfer; in-flight entries are lost.
- Definitions:
  - in_fire = valid_i & ready_o.
  - out_fire = valid_o & ready_i & ~stall_i.
- States: EMPTY (no entry), ONE (main register holds an entry), TWO (main + skid both hold entries).
- Transitions, when flush_i=0:
  - EMPTY: in_fire -> ONE, main<=input.
  - ONE:
    - in_fire & out_fire -> ONE, main<=input.
    - in_fire & ~out_fire -> TWO, skid<=input.
    - ~in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - TWO: ready_o=0, so there is no in_fire. out_fire -> ONE, main<=skid. Otherwise hold.
- Outputs and timing:
  - ready_o is registered: 1 in EMPTY and ONE, 0 in TWO, updated together with the state.
  - valid_o=1 in ONE and TWO. data_o and ctrl_o always come from the main register.
  - Latency: an entry accepted at edge N appears on the outputs after edge N when the stage was EMPTY.
  - Throughput: one entry per cycle with no bubbles while ready_i=1 and stall_i=0.
- Stall:
  - stall_i=1 blocks out_fire regardless of ready_i; outputs hold stable.
  - Input is still accepted while ready_o=1, filling the skid entry.
  - data_o and ctrl_o must not change while valid_o=1 and no out_fire occurs.
- Flush:
  - flush_i=1 at an edge: state->EMPTY, valid_o->0, ctrl_o->0, ready_o->1. data_o keeps its old value (don't-care).
  - A same-cycle in_fire is dropped.
  - Flush dominates stall_i, valid_i and ready_i.
  - stall_cnt_o is not incremented on a flush edge.
- Bubble rule: whenever valid_o=0, ctrl_o=0, so downstream write/mem enables are inert.
- Counter:
  - Increments on each edge where valid_o=1, out_fire=0 and flush_i=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Order is preserved: the skid entry is always older than any later input and younger than main.

Test Plan:
- Reset mid-stream: hold start_i=0 while state=TWO -> immediately valid_o=0, ready_o=1, ctrl_o=0, stall_cnt_o=0, without waiting for a clock edge.
- Streaming: valid_i=1 with data 1..8, ready_i=1, stall_i=0 -> data_o shows 1..8 on consecutive cycles, one cycle behind; ready_o stays 1; stall_cnt_o=0.
- Backpressure:
  - Send 0xA then 0xB with ready_i=0 -> state TWO, ready_o=0 after the 2nd edge, data_o=0xA.
  - Raise ready_i -> outputs 0xA then 0xB in order; ready_o returns to 1 one cycle after the first out_fire.
- Stall: stall_i=1 for 5 cycles with ready_i=1 and one valid entry held -> data_o/ctrl_o stable, stall_cnt_o=5; after release the entry transfers once.
- Flush with input: state TWO, flush_i=1 with valid_i=1, ctrl_i=0xFF -> next cycle valid_o=0, ctrl_o=0, ready_o=1; neither held entry nor the flushed input ever appears.
- Saturation: CNT_W=4, hold 20 blocked cycles -> stall_cnt_o stops at 15 and does not wrap to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with a 2-entry skid buffer, a registered ready,
// a synchronous flush that inserts a bubble, and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;

  assign valid_o     = (state_q != EMPTY);
  assign ready_o     = ready_q;
  assign data_o      = main_data_q;
  // Bubbles must never carry live write/mem enables downstream.
  assign ctrl_o      = valid_o ? main_ctrl_q : '0;
  assign stall_cnt_o = cnt_q;

  assign in_fire  = valid_i & ready_q;
  assign out_fire = valid_o & ready_i & ~stall_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    cnt_d       = cnt_q;

    if (flush_i) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d     = ONE;
          main_data_d = data_i;
          main_ctrl_d = ctrl_i;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = data_i;
            main_ctrl_d = ctrl_i;
          end else if (in_fire) begin
            state_d     = TWO;
            skid_data_d = data_i;
            skid_ctrl_d = ctrl_i;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: if (out_fire) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
        default: state_d = EMPTY;
      endcase
      if (valid_o && !out_fire && (cnt_q != '1))
        cnt_d = cnt_q + 1'b1;
    end

    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q     <= EMPTY;
      ready_q     <= 1'b1;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second narrow-counter instance shares the inputs.
module tb_pipe_stage_reg;
  localparam int DW = 64;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          start_n, flush, stall, vin, rdy_in;
  logic [DW-1:0] din;
  logic [CW-1:0] cin;
  logic          rdy_o, vld_o, rdy_o4, vld_o4;
  logic [DW-1:0] dout, dout4;
  logic [CW-1:0] cout, cout4;
  logic [15:0]   cnt;
  logic [3:0]    cnt4;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk_i(clk), .start_i(start_n), .flush_i(flush), .stall_i(stall),
    .valid_i(vin), .ready_o(rdy_o), .data_i(din), .ctrl_i(cin),
    .valid_o(vld_o), .ready_i(rdy_in), .data_o(dout), .ctrl_o(cout),
    .stall_cnt_o(cnt));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .clk_i(clk), .start_i(start_n), .flush_i(flush), .stall_i(stall),
    .valid_i(vin), .ready_o(rdy_o4), .data_i(din), .ctrl_i(cin),
    .valid_o(vld_o4), .ready_i(rdy_in), .data_o(dout4), .ctrl_o(cout4),
    .stall_cnt_o(cnt4));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    flush = 0; stall = 0; vin = 0; rdy_in = 0; din = '0; cin = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    start_n = 0;
    step(); step();
    start_n = 1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    start_n = 0;
    step(); step();
    checks++;
    if ({vld_o, rdy_o, dout, cout, cnt} !== {1'b1 ^ 1'b1, 1'b1, 64'd0, 8'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state: got v=%b r=%b d=%h c=%h n=%0d, want v=0 r=1 d=0 c=0 n=0",
               vld_o, rdy_o, dout, cout, cnt);
    end
    start_n = 1;
    step();
  endtask

  task automatic test_streaming();
    do_reset();
    rdy_in = 1; vin = 1;
    for (int k = 1; k <= 8; k++) begin
      din = DW'(k); cin = CW'(k + 16);
      step();
      checks++;
      if (vld_o !== 1'b1 || dout !== DW'(k) || cout !== CW'(k + 16) || rdy_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b d=%0d c=%h r=%b, want v=1 d=%0d c=%h r=1",
                 k, vld_o, dout, cout, rdy_o, k, k + 16);
      end
    end
    vin = 0;
    step();
    checks++;
    if (vld_o !== 1'b0 || cout !== 8'd0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b c=%h n=%0d, want v=0 c=00 n=0", vld_o, cout, cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_in = 0; vin = 1; din = 64'hA; cin = 8'h0A;
    step();
    din = 64'hB; cin = 8'h0B;
    step();
    checks++;
    if (rdy_o !== 1'b0 || vld_o !== 1'b1 || dout !== 64'hA) begin
      errors++;
      $display("FAIL bp_full: got r=%b v=%b d=%h, want r=0 v=1 d=a", rdy_o, vld_o, dout);
    end
    vin = 0; rdy_in = 1;
    step();
    checks++;
    if (vld_o !== 1'b1 || dout !== 64'hB || cout !== 8'h0B || rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got v=%b d=%h c=%h r=%b, want v=1 d=b c=0b r=1",
               vld_o, dout, cout, rdy_o);
    end
    step();
    checks++;
    if (vld_o !== 1'b0 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL bp_drain: got v=%b n=%0d, want v=0 n=1", vld_o, cnt);
    end
  endtask

  task automatic test_stall();
    do_reset();
    rdy_in = 1; vin = 1; din = 64'h55; cin = 8'h3C;
    step();
    vin = 0; stall = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (vld_o !== 1'b1 || dout !== 64'h55 || cout !== 8'h3C || cnt !== 16'(k)) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v=%b d=%h c=%h n=%0d, want v=1 d=55 c=3c n=%0d",
                 k, vld_o, dout, cout, cnt, k);
      end
    end
    stall = 0;
    step();
    checks++;
    if (vld_o !== 1'b0 || cout !== 8'd0 || cnt !== 16'd5) begin
      errors++;
      $display("FAIL stall_release: got v=%b c=%h n=%0d, want v=0 c=00 n=5", vld_o, cout, cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    rdy_in = 0; vin = 1; din = 64'h11; cin = 8'h01;
    step();
    din = 64'h22; cin = 8'h02;
    step();
    flush = 1; din = 64'h33; cin = 8'hFF;
    step();
    checks++;
    if (vld_o !== 1'b0 || cout !== 8'd0 || rdy_o !== 1'b1 || cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_edge: got v=%b c=%h r=%b n=%0d, want v=0 c=00 r=1 n=1",
               vld_o, cout, rdy_o, cnt);
    end
    flush = 0; vin = 0; rdy_in = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (vld_o !== 1'b0 || cout !== 8'd0) begin
        errors++;
        $display("FAIL flush_leak_%0d: got v=%b c=%h d=%h, want v=0 c=00", k, vld_o, cout, dout);
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    rdy_in = 0; vin = 1; din = 64'h77; cin = 8'h77;
    step(); step(); step();
    vin = 0;
    #1 start_n = 0;
    #1;
    checks++;
    if (vld_o !== 1'b0 || rdy_o !== 1'b1 || cout !== 8'd0 || cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%b c=%h n=%0d, want v=0 r=1 c=00 n=0",
               vld_o, rdy_o, cout, cnt);
    end
    start_n = 1;
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    rdy_in = 1; vin = 1; din = 64'h9; cin = 8'h9;
    step();
    vin = 0; stall = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15 || k == 16 || k == 20) begin
        checks++;
        if (cnt4 !== 4'd15 || cnt !== 16'(k)) begin
          errors++;
          $display("FAIL sat_%0d: got n4=%0d n16=%0d, want n4=15 n16=%0d", k, cnt4, cnt, k);
        end
      end
    end
    stall = 0;
    step();
  endtask

  initial begin
    start_n = 0;
    idle_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
    test_reset_midstream();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
